// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared constants for the multiplexed 7-segment driver: character codes and
// active-low segment patterns (bit 6 = segment a ... bit 0 = segment g).
// No ports; imported by led_char_decoder and multi_digit_led_driver.
// -----------------------------------------------------------------------------
package led_pkg;

  typedef logic [3:0] char_t;
  typedef logic [6:0] seg_t;

  // Character codes. 0x0-0x9 are decimal digits; 0xC-0xF all render blank.
  localparam char_t CH_DASH  = 4'hA;
  localparam char_t CH_F     = 4'hB;
  localparam char_t CH_BLANK = 4'hC;

  // Active-low segment patterns, order a,b,c,d,e,f,g from MSB to LSB.
  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_DASH  = 7'b1111110;
  localparam seg_t SEG_F     = 7'b0111000;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/led_char_decoder.sv
// -----------------------------------------------------------------------------
// led_char_decoder
// Purely combinational character-code to 7-segment decode.
// Ports:
//   code  in  4  character code (see led_pkg)
//   seg   out 7  active-low segments a..g, MSB = a
// -----------------------------------------------------------------------------
module led_char_decoder
  import led_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      CH_DASH: seg = SEG_DASH;
      CH_F:    seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/multi_digit_led_driver.sv
// -----------------------------------------------------------------------------
// multi_digit_led_driver
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
// Each digit owns a slot of REFRESH_DIV clocks; the first DEAD_CYCLES clocks of
// every slot blank all anodes to avoid ghosting. New characters are captured
// into a shadow register on 'load' and moved to the display register only at a
// frame boundary (last cycle of the last digit's slot), so a frame never mixes
// old and new characters.
//
// Parameters:
//   NUM_DIGITS   1..8            number of digits
//   REFRESH_DIV  >= 4            clocks per digit slot
//   DEAD_CYCLES  0..REFRESH_DIV-1 blanked clocks at start of each slot
//   BLINK_FRAMES (LED_BLINK_EN)  frame boundaries per blink phase toggle
//
// Ports:
//   clk         in   1              rising-edge clock
//   reset       in   1              asynchronous active-low reset
//   load        in   1              strobe capturing chars
//   chars       in   4*NUM_DIGITS   digit i = chars[4i+3:4i]
//   blink_mask  in   NUM_DIGITS     (LED_BLINK_EN only) digits that blink
//   pending     out  1              captured chars not yet displayed
//   anode       out  NUM_DIGITS     active-low digit enables
//   led         out  7              active-low segments a..g, MSB = a
//
// Build option: define LED_BLINK_EN to add blink_mask / BLINK_FRAMES and the
// blink frame counter. Without it every digit is always visible.
// -----------------------------------------------------------------------------
module multi_digit_led_driver
  import led_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int DEAD_CYCLES  = 4
`ifdef LED_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] chars,
`ifdef LED_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic                    pending,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              led
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]                slot_cnt;
  logic [IDX_W-1:0]                digit_idx;
  logic [NUM_DIGITS-1:0][3:0]      shadow;
  logic [NUM_DIGITS-1:0][3:0]      display;

  logic                            slot_tc;
  logic                            frame_bnd;
  logic                            in_dead;
  logic [3:0]                      cur_char;
  logic [6:0]                      cur_seg;
  logic [NUM_DIGITS-1:0]           anode_on;
  logic                            blank_digit;

  assign slot_tc   = (slot_cnt == CNT_LAST);
  assign frame_bnd = slot_tc && (digit_idx == IDX_LAST);
  assign in_dead   = (32'(slot_cnt) < DEAD_CYCLES);
  assign cur_char  = display[digit_idx];
  assign anode_on  = ~(NUM_DIGITS'(1) << digit_idx);

  // ---------------------------------------------------------------------------
  // Slot counter and digit index
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_tc) begin
      slot_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      slot_cnt  <= slot_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow / display double buffer. A load that lands on the boundary goes
  // straight to the display, so nothing is left waiting.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow  <= {NUM_DIGITS{CH_BLANK}};
      display <= {NUM_DIGITS{CH_BLANK}};
      pending <= 1'b0;
    end else if (frame_bnd) begin
      if (load) begin
        shadow  <= chars;
        display <= chars;
      end else if (pending) begin
        display <= shadow;
      end
      pending <= 1'b0;
    end else if (load) begin
      shadow  <= chars;
      pending <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional blink phase: down-counter over frame boundaries, toggling the
  // phase at terminal count.
  // ---------------------------------------------------------------------------
`ifdef LED_BLINK_EN
  localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FR_W-1:0] FR_RELOAD = FR_W'(BLINK_FRAMES - 1);

  logic [FR_W-1:0] frame_cnt;
  logic            blink_phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt   <= FR_RELOAD;
      blink_phase <= 1'b0;
    end else if (frame_bnd) begin
      if (frame_cnt == '0) begin
        frame_cnt   <= FR_RELOAD;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt   <= frame_cnt - 1'b1;
      end
    end
  end

  assign blank_digit = blink_phase & blink_mask[digit_idx];
`else
  assign blank_digit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Character decode on the currently scanned digit
  // ---------------------------------------------------------------------------
  led_char_decoder u_decoder (
    .code (cur_char),
    .seg  (cur_seg)
  );

  // ---------------------------------------------------------------------------
  // Registered outputs: one clock behind the counter/index that select them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anode <= '1;
      led   <= SEG_BLANK;
    end else if (in_dead) begin
      anode <= '1;
      led   <= SEG_BLANK;
    end else begin
      anode <= anode_on;
      led   <= blank_digit ? SEG_BLANK : cur_seg;
    end
  end

endmodule

// File: tb/tb_multi_digit_led_driver.sv
// -----------------------------------------------------------------------------
// tb_multi_digit_led_driver
// Directed bench for multi_digit_led_driver with NUM_DIGITS=4, REFRESH_DIV=8,
// DEAD_CYCLES=2 (and BLINK_FRAMES=2, blink_mask=4'b0010 when LED_BLINK_EN is
// defined). 'pos' labels each sampled cycle with the counter position whose
// outputs are visible in it: pos%8 = slot count, (pos/8)%4 = digit, pos/32 =
// frame since reset.
// -----------------------------------------------------------------------------
module tb_multi_digit_led_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int DC = 2;
  localparam int FRAME = ND * RD;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        load  = 1'b0;
  logic [15:0] chars = 16'h0000;
  logic        pending;
  logic [3:0]  anode;
  logic [6:0]  led;
`ifdef LED_BLINK_EN
  logic [3:0]  blink_mask = 4'b0010;
`endif

  int checks   = 0;
  int failures = 0;
  int pos      = 0;

  // Expected on-screen characters and the set queued for the next frame.
  logic [15:0] disp_model = 16'hCCCC;
  logic [15:0] next_model = 16'hCCCC;
  bit          swap       = 1'b0;

  always #5 clk = ~clk;

  multi_digit_led_driver #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .DEAD_CYCLES  (DC)
`ifdef LED_BLINK_EN
    ,
    .BLINK_FRAMES (2)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .chars      (chars),
`ifdef LED_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .pending    (pending),
    .anode      (anode),
    .led        (led)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'h0: seg_of = 7'b0000001;
      4'h1: seg_of = 7'b1001111;
      4'h2: seg_of = 7'b0010010;
      4'h3: seg_of = 7'b0000110;
      4'h4: seg_of = 7'b1001100;
      4'h5: seg_of = 7'b0100100;
      4'h6: seg_of = 7'b0100000;
      4'h7: seg_of = 7'b0001111;
      4'h8: seg_of = 7'b0000000;
      4'h9: seg_of = 7'b0000100;
      4'hA: seg_of = 7'b1111110;
      4'hB: seg_of = 7'b0111000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  task automatic check1(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and check the scanned outputs against the model.
  task automatic tick();
    logic [3:0] exp_an;
    logic [6:0] exp_led;
    int         cnt;
    int         idx;
    @(posedge clk);
    #1;
    if ((pos % FRAME == 0) && swap) begin
      disp_model = next_model;
      swap       = 1'b0;
    end
    cnt = pos % RD;
    idx = (pos / RD) % ND;
    if (cnt < DC) begin
      exp_an  = 4'hF;
      exp_led = 7'h7F;
    end else begin
      exp_an  = ~(4'b0001 << idx);
      exp_led = seg_of(disp_model[4*idx +: 4]);
`ifdef LED_BLINK_EN
      if ((((pos / FRAME) / 2) % 2 == 1) && blink_mask[idx]) exp_led = 7'h7F;
`endif
    end
    check1($sformatf("anode@%0d", pos), 16'(anode), 16'(exp_an));
    check1($sformatf("led@%0d", pos), 16'(led), 16'(exp_led));
    pos++;
  endtask

  // Present chars for one cycle; it is captured at counter position 'pos'.
  task automatic do_load(input logic [15:0] c);
    load       = 1'b1;
    chars      = c;
    next_model = c;
    swap       = 1'b1;
    tick();
    load       = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check1("rst_anode",   16'(anode),   16'h000F);
    check1("rst_led",     16'(led),     16'h007F);
    check1("rst_pending", 16'(pending), 16'h0000);
    reset = 1'b1;

    // Frame 0: blank scan with dead time per slot
    repeat (FRAME) tick();

    // Mid-frame load of 1230, shown from frame 2
    repeat (4) tick();
    do_load(16'h1230);
    check1("pend_after_load", 16'(pending), 16'h0001);
    while (pos < 63) tick();
    check1("pend_before_bnd", 16'(pending), 16'h0001);
    tick();
    check1("pend_after_bnd", 16'(pending), 16'h0000);

    // Two loads in one frame: only the latest (ABCC) is shown
    repeat (6) tick();
    do_load(16'h9999);
    do_load(16'hABCC);
    check1("pend_overwrite", 16'(pending), 16'h0001);
    while (pos < 127) tick();
    check1("pend_cleared_f3", 16'(pending), 16'h0000);

    // Load on the boundary cycle: shown immediately, never pending
    do_load(16'h5678);
    check1("pend_bnd_load", 16'(pending), 16'h0000);
    repeat (8) tick();

    // Reset with a load pending: outputs clear at once, 4444 never shown
    do_load(16'h4444);
    check1("pend_before_rst", 16'(pending), 16'h0001);
    #3 reset = 1'b0;
    #1;
    check1("async_rst_anode",   16'(anode),   16'h000F);
    check1("async_rst_led",     16'(led),     16'h007F);
    check1("async_rst_pending", 16'(pending), 16'h0000);
    @(posedge clk);
    #1;
    reset      = 1'b1;
    pos        = 0;
    disp_model = 16'hCCCC;
    next_model = 16'hCCCC;
    swap       = 1'b0;

    repeat (70) tick();
    check1("pend_post_rst", 16'(pending), 16'h0000);

    // 8888 from frame 3 onward; with blink, digit 1 dark in frames 2-3
    do_load(16'h8888);
    while (pos < 6 * FRAME) tick();
    check1("pend_end", 16'(pending), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
